pulse_period_meter: RTL

Measures the high time and low time of a single-bit pulse stream, such as the pulse output of the 8-bit pulse generator, in Clk cycles. Each completed period (rising edge to the next rising edge) produces one result word. Results are handed off on a valid/ready handshake to a downstream consumer, either a display/readout stage or the bench checker. The block is the consumer stage directly downstream of the pulse generator.

---
 rtl/pulse_period_meter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures high/low time of each pulse period and hands results off on valid/ready
module pulse_period_meter #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             enable,
    input  logic             pulse,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] high_len,
    output logic [WIDTH-1:0] low_len,
    output logic             overflow,
    output logic             missed
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] hcnt;
    logic [WIDTH-1:0] hcnt_d;
    logic [WIDTH-1:0] lcnt;
    logic [WIDTH-1:0] lcnt_d;
    logic             ovf;
    logic             ovf_d;
    logic             publish;

    // pulse is asynchronous: two flops for metastability, a third for edge detection
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pulse;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            hcnt  <= hcnt_d;
            lcnt  <= lcnt_d;
            ovf   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        lcnt_d  = lcnt;
        ovf_d   = ovf;
        publish = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        hcnt_d  = CNT_ONE;
                        ovf_d   = 1'b0;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        lcnt_d  = CNT_ONE;
                    end else if (s2) begin
                        if (hcnt == CNT_MAX) ovf_d = 1'b1;
                        else hcnt_d = hcnt + CNT_ONE;
                    end
                end
                LOW: begin
                    // a rising edge closes this period and opens the next one
                    if (rise) begin
                        publish = 1'b1;
                        state_d = HIGH;
                        hcnt_d  = CNT_ONE;
                        ovf_d   = 1'b0;
                    end else if (!s2) begin
                        if (lcnt == CNT_MAX) ovf_d = 1'b1;
                        else lcnt_d = lcnt + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid    <= 1'b0;
            high_len <= '0;
            low_len  <= '0;
            overflow <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (!enable) missed <= 1'b0;
            if (publish) begin
                if (!valid || ready) begin
                    valid    <= 1'b1;
                    high_len <= hcnt;
                    low_len  <= lcnt;
                    overflow <= ovf;
                end else begin
                    missed <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
